o_delay_tap_ctrl: RTL

Control stage for the output delay path: it sits directly upstream of the O_DELAY primitive and drives its DLY_LOAD, DLY_ADJ and DLY_INCDEC inputs. It takes a target tap value over a valid/ready request interface and walks the O_DELAY tap to that value one step at a time. After each step it waits for a settle interval and, optionally, checks the DLY_TAP_VALUE readback. It replaces manually driven delay-control inputs in the output-delay test designs.

---
 rtl/o_delay_pkg.sv | 13 +
 rtl/o_delay_tap_ctrl_if.sv | 23 ++
 rtl/o_delay_wait_cnt.sv | 18 +
 rtl/o_delay_tap_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/o_delay_pkg.sv
// o_delay_pkg: shared state encoding and default tap width for the O_DELAY control blocks
package o_delay_pkg;
  localparam int TAP_W_DEF = 6;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_SETTLE,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_e;
endpackage

// File: rtl/o_delay_tap_ctrl_if.sv
// o_delay_tap_ctrl_if: tap request channel between a requester and the tap controller
interface o_delay_tap_ctrl_if
  import o_delay_pkg::*;
#(
  parameter int TAP_W = TAP_W_DEF
);
  logic             req_valid;
  logic             req_ready;
  logic [TAP_W-1:0] req_tap;
  logic             req_load;
  logic             busy;
  logic             done;
  logic             err;
  logic [TAP_W-1:0] cur_tap;
  modport master (
    output req_valid, req_tap, req_load,
    input  req_ready, busy, done, err, cur_tap
  );
  modport slave (
    input  req_valid, req_tap, req_load,
    output req_ready, busy, done, err, cur_tap
  );
endinterface

// File: rtl/o_delay_wait_cnt.sv
// o_delay_wait_cnt: loadable down-counter that stops at zero and flags terminal count
module o_delay_wait_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end
  assign tc_o = cnt_q == '0;
endmodule

// File: rtl/o_delay_tap_ctrl.sv
// o_delay_tap_ctrl: walks the O_DELAY tap to a requested value one settled step at a time.
// Define O_DELAY_READBACK_CHK_EN to also verify DLY_TAP_VALUE after every action, with a timeout.
module o_delay_tap_ctrl
  import o_delay_pkg::*;
#(
  parameter int TAP_W       = TAP_W_DEF,
  parameter int INIT_TAP    = 0,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  o_delay_tap_ctrl_if.slave  req,
  output logic               dly_ld_o,
  output logic               dly_adj_o,
  output logic               dly_incdec_o,
  input  logic [TAP_W-1:0]   dly_tap_val_i
);
`ifdef O_DELAY_READBACK_CHK_EN
  localparam int CNT_MAX = SETTLE_CYC > TIMEOUT_CYC ? SETTLE_CYC : TIMEOUT_CYC;
`else
  localparam int CNT_MAX = SETTLE_CYC;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  state_e           state_q, state_d;
  logic [TAP_W-1:0] tgt_q, tgt_d, cur_q;
  logic             sync_lost_q, ld_q, adj_q, incdec_q, done_q;
  logic             cnt_ld, cnt_tc, rb_ok;
  logic [CNT_W-1:0] cnt_val;
  o_delay_wait_cnt #(.W(CNT_W)) u_wait (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (cnt_ld),
    .val_i  (cnt_val),
    .tc_o   (cnt_tc)
  );
`ifdef O_DELAY_READBACK_CHK_EN
  logic err_q;
  assign rb_ok   = dly_tap_val_i == cur_q;
  // one counter serves both intervals: settle on each pulse, timeout on entering CHECK
  assign cnt_ld  = state_q inside {S_LOAD, S_STEP} || (state_q == S_SETTLE && cnt_tc);
  assign cnt_val = state_q == S_SETTLE ? CNT_W'(TIMEOUT_CYC - 1) : CNT_W'(SETTLE_CYC - 1);
  assign req.err = err_q;
  always_ff @(posedge clk_i) err_q <= !rst_i && state_d == S_ERR;
`else
  logic unused_rb;
  assign unused_rb = ^dly_tap_val_i;
  assign rb_ok     = 1'b1;
  assign cnt_ld    = state_q inside {S_LOAD, S_STEP};
  assign cnt_val   = CNT_W'(SETTLE_CYC - 1);
  assign req.err   = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    case (state_q)
      S_IDLE: if (req.req_valid) begin
        tgt_d   = req.req_tap;
        state_d = (req.req_load || sync_lost_q) ? S_LOAD :
                  (req.req_tap != cur_q) ? S_STEP : S_DONE;
      end
      S_LOAD, S_STEP: state_d = S_SETTLE;
      S_SETTLE: state_d = cnt_tc ? S_CHECK : S_SETTLE;
      S_CHECK: state_d = !rb_ok ? (cnt_tc ? S_ERR : S_CHECK) :
                         (cur_q != tgt_q) ? S_STEP : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      tgt_q       <= TAP_W'(INIT_TAP);
      cur_q       <= TAP_W'(INIT_TAP);
      sync_lost_q <= 1'b1;
      ld_q        <= 1'b0;
      adj_q       <= 1'b0;
      incdec_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      ld_q        <= state_d == S_LOAD;
      adj_q       <= state_d == S_STEP;
      done_q      <= state_d == S_DONE;
      if (state_d == S_STEP) incdec_q <= tgt_d > cur_q;
      cur_q       <= state_q == S_LOAD ? TAP_W'(INIT_TAP) :
                     state_q == S_STEP ? (incdec_q ? cur_q + 1'b1 : cur_q - 1'b1) : cur_q;
      sync_lost_q <= state_q == S_LOAD ? 1'b0 : sync_lost_q | (state_d == S_ERR);
    end
  end
  assign req.req_ready = state_q == S_IDLE;
  assign req.busy      = state_q != S_IDLE;
  assign req.done      = done_q;
  assign req.cur_tap   = cur_q;
  assign dly_ld_o      = ld_q;
  assign dly_adj_o     = adj_q;
  assign dly_incdec_o  = incdec_q;
endmodule
